// File: rtl/bin2bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_ctrl
// Brief    : 6-bit binary to two-digit BCD by repeated subtract-10 through a
//            single shared subtractor, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [2:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SUB  = 1'b1
    } state_t;

    localparam logic [5:0] c_TEN = 6'd10;

    state_t     r_state, w_state_next;
    logic [5:0] r_rem,   w_rem_next;
    logic [2:0] r_cnt,   w_cnt_next;
    logic       r_busy,  w_busy_next;
    logic       r_done,  w_done_next;
    logic [2:0] r_tens,  w_tens_next;
    logic [3:0] r_ones,  w_ones_next;

    // Two's-complement subtract; the carry out doubles as the "rem >= 10" flag.
    logic [6:0] w_sum;
    logic       w_no_borrow;
    logic [5:0] w_diff;

    assign w_sum       = {1'b0, r_rem} + {1'b0, ~c_TEN} + 7'd1;
    assign w_no_borrow = w_sum[6];
    assign w_diff      = w_sum[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= 6'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tens  <= 3'd0;
            r_ones  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_tens  <= w_tens_next;
            r_ones  <= w_ones_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;

        unique case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                if (start) begin
                    w_rem_next   = bin;
                    w_cnt_next   = 3'd0;
                    w_busy_next  = 1'b1;
                    w_state_next = S_SUB;
                end
            end
            S_SUB: begin
                if (w_no_borrow) begin
                    w_rem_next = w_diff;
                    w_cnt_next = r_cnt + 3'd1;
                end else begin
                    // Remainder is below 10 here, so its upper bits are zero.
                    w_tens_next  = r_cnt;
                    w_ones_next  = r_rem[3:0];
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign tens = r_tens;
    assign ones = r_ones;

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq_ctrl.md
# bin2bcd_seq_ctrl

Sequential controller that converts a 6-bit unsigned binary value (0–63) into two BCD digits, tens and ones, by repeated subtract-10 iterations through one shared 6-bit subtract datapath. It sits between the game logic, which produces the guess and target values, and the VGA digit renderer, which consumes BCD digits. A start/busy/done handshake allows one conversion at a time. Results are held stable between conversions for the display path.

## Interface
- Parameters: none. Input width (6), subtrahend (10) and digit widths are fixed.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  6  unsigned binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress; registered.
- done  out  1  one-cycle pulse when tens/ones are updated; registered.
- tens  out  3  BCD tens digit, 0–6; registered, held until the next done.
- ones  out  4  BCD ones digit, 0–9; registered, held until the next done.

## Operation
- Internal state:
  - FSM state: IDLE or SUB.
  - rem[5:0]: working remainder.
  - cnt[2:0]: tens accumulator.
- Subtract datapath: diff = rem − 6'd10, computed as rem + ~10 + 1.
  - The carry out is the no-borrow flag: 1 when rem ≥ 10.
  - Exactly one subtraction is evaluated per cycle, always on rem.
- IDLE:
  - busy=0.
  - If start=1: rem ← bin, cnt ← 0, busy ← 1, go to SUB.
  - Otherwise hold.
- SUB:
  - If no-borrow (rem ≥ 10): rem ← diff[5:0], cnt ← cnt+1, stay in SUB.
  - Else: tens ← cnt, ones ← rem[3:0], done ← 1, busy ← 0, go to IDLE.
- Iteration count k = bin/10 (0..6).
  - cnt never exceeds 6.
  - rem[5:4] = 0 on exit.
- start while busy=1 is ignored, not queued.
  - bin changes during a conversion have no effect.
- start in the cycle done=1 is accepted (FSM is already in IDLE) and begins a new conversion.
- done is high for exactly one cycle per completed conversion and is deasserted on every other cycle.
- Reset (any state, including mid-conversion):
  - Forces IDLE; busy=0, done=0, tens=0, ones=0, rem=0, cnt=0.
  - An aborted conversion produces no done pulse.
  - start asserted in the same cycle as rst is ignored.

## Timing
- The cycle in which start=1 is sampled in IDLE is cycle 0.
- busy is high in cycles 1..k+1.
- In cycle k+2:
  - done=1, busy=0, tens/ones hold the new result.
  - A new start may be sampled.
- Latency from start to done: k+2 cycles.
  - Best case is bin<10: 2 cycles.
  - Worst case is bin 60–63: 8 cycles.
- Throughput with back-to-back starts (start held high): one result every k+2 cycles.
- tens/ones change only on the edge that raises done; they are stable for all other cycles, including during busy.
- No combinational path from any input to any output.

## Test plan
- Reset, then idle:
  - Expect tens=0, ones=0, busy=0, done=0.
  - With start=0 for 10 cycles, expect no change.
- bin=0, start pulse:
  - Expect done in cycle 2 with tens=0, ones=0.
  - bin=9: expect done in cycle 2 with tens=0, ones=9.
- bin=10:
  - Expect done in cycle 3 with tens=1, ones=0.
  - bin=63: expect done in cycle 8 with tens=6, ones=3; busy high in cycles 1–7.
- Exhaustive sweep, bin 0..63 with start held high:
  - Each done gives tens=bin/10, ones=bin%10 for the value captured.
  - Exactly one done per conversion; next busy begins the cycle after done.
- Start during busy:
  - Start bin=57, then pulse start with bin=12 in cycle 3.
  - Expect a single done in cycle 7 with tens=5, ones=7, and no second conversion.
- Reset mid-conversion:
  - Start bin=45 and assert rst in cycle 2.
  - Expect busy=0, tens=0, ones=0 after the edge and no done pulse.
  - Then start bin=21: expect done in cycle 4 with tens=2, ones=1.
